// File: rtl/phased_array_driver.sv
// Phased-array transducer driver: per-channel phase-shifted PWM inside a movable WINxWIN window, set by byte packets.
// Optional PHASED_ARRAY_ERR_CNT_EN macro enables the saturating malformed-packet counter on err_cnt.
module phased_array_driver #(
    parameter int NX      = 8,
    parameter int NY      = 8,
    parameter int WIN     = 4,
    parameter int PHASE_W = 10,
    parameter int DUTY    = 2 ** (PHASE_W - 1),
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [NX*NY-1:0]       wav_out,
    output logic [$clog2(NX)-1:0]  win_x,
    output logic [$clog2(NY)-1:0]  win_y,
    output logic                   pkt_ok,
    output logic                   pkt_err,
    output logic [7:0]             err_cnt
);
    localparam int NCH = NX * NY;
    localparam int XW  = $clog2(NX);
    localparam int YW  = $clog2(NY);
    localparam int IW  = $clog2(NCH);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [XW-1:0]      X_MAX   = XW'(NX - WIN);
    localparam logic [YW-1:0]      Y_MAX   = YW'(NY - WIN);
    localparam logic [XW-1:0]      X_RST   = XW'((NX - WIN) / 2);
    localparam logic [YW-1:0]      Y_RST   = YW'((NY - WIN) / 2);
    localparam logic [PHASE_W:0]   DUTY_V  = (PHASE_W + 1)'(DUTY);
    localparam logic [TW-1:0]      TMO_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CMD, ARG, END} state_t;

    state_t               state;
    logic [7:0]           cmd;
    logic [7:0]           arg;
    logic [TW-1:0]        tmo;
    logic [IW-1:0]        idx;
    logic [PHASE_W-1:0]   cnt;
    logic [PHASE_W-1:0]   gphase_sh;
    logic [PHASE_W-1:0]   gphase;
    logic [PHASE_W-1:0]   chphase_sh [NCH];
    logic [PHASE_W-1:0]   chphase    [NCH];
    logic [XW-1:0]        win_x_sh;
    logic [YW-1:0]        win_y_sh;
    logic [NCH-1:0]       wav_next;
    logic                 cmd_known;
    logic                 pkt_bad;

    function automatic logic [PHASE_W-1:0] scale(input logic [7:0] a);
        return PHASE_W'(a) << (PHASE_W - 8);
    endfunction

    always_comb begin
        cmd_known = 1'b0;
        case (cmd)
            8'h41, 8'h44, 8'h57, 8'h53, 8'h50, 8'h49, 8'h56: cmd_known = 1'b1;
            default: cmd_known = 1'b0;
        endcase
        pkt_bad = (rx_data != 8'h3C) || !cmd_known || (cmd == 8'h49 && 32'(arg) >= NCH);
    end

    // Parser: bytes land in shadow registers; nothing visible changes until the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd       <= '0;
            arg       <= '0;
            tmo       <= '0;
            idx       <= '0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            gphase_sh <= '0;
            win_x_sh  <= X_RST;
            win_y_sh  <= Y_RST;
            for (int i = 0; i < NCH; i++) chphase_sh[i] <= '0;
        end else begin
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            if (rx_valid) begin
                tmo <= '0;
                case (state)
                    IDLE: if (rx_data == 8'hFF) state <= CMD;
                    CMD: begin
                        cmd   <= rx_data;
                        state <= ARG;
                    end
                    ARG: begin
                        arg   <= rx_data;
                        state <= END;
                    end
                    END: begin
                        state <= IDLE;
                        if (pkt_bad) begin
                            pkt_err <= 1'b1;
                        end else begin
                            pkt_ok <= 1'b1;
                            case (cmd)
                                8'h41: begin
                                    if (win_x_sh != '0) win_x_sh <= win_x_sh - 1'b1;
                                    gphase_sh <= scale(arg);
                                end
                                8'h44: begin
                                    if (win_x_sh < X_MAX) win_x_sh <= win_x_sh + 1'b1;
                                    gphase_sh <= scale(arg);
                                end
                                8'h57: begin
                                    if (win_y_sh != '0) win_y_sh <= win_y_sh - 1'b1;
                                    gphase_sh <= scale(arg);
                                end
                                8'h53: begin
                                    if (win_y_sh < Y_MAX) win_y_sh <= win_y_sh + 1'b1;
                                    gphase_sh <= scale(arg);
                                end
                                8'h50: gphase_sh <= scale(arg);
                                8'h49: idx <= IW'(arg);
                                8'h56: begin
                                    chphase_sh[idx] <= scale(arg);
                                    idx <= (idx == IW'(NCH - 1)) ? '0 : idx + 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo == TMO_END) begin
                    state   <= IDLE;
                    tmo     <= '0;
                    pkt_err <= 1'b1;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
        end
    end

    // Carrier counter; active settings are reloaded on the cycle it wraps so no period is ever split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            gphase <= '0;
            win_x  <= X_RST;
            win_y  <= Y_RST;
            for (int i = 0; i < NCH; i++) chphase[i] <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                gphase <= gphase_sh;
                win_x  <= win_x_sh;
                win_y  <= win_y_sh;
                for (int i = 0; i < NCH; i++) chphase[i] <= chphase_sh[i];
            end
        end
    end

    always_comb begin
        wav_next = '0;
        for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
                wav_next[y*NX+x] = (x >= int'(win_x)) && (x <= int'(win_x) + WIN - 1) &&
                                   (y >= int'(win_y)) && (y <= int'(win_y) + WIN - 1) &&
                                   ({1'b0, PHASE_W'(cnt + gphase + chphase[y*NX+x])} < DUTY_V);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wav_out <= '0;
        else        wav_out <= wav_next;
    end

`ifdef PHASED_ARRAY_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt <= '0;
        else if (pkt_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_phased_array_driver.sv
// Directed bench for phased_array_driver: packet table, period-boundary commit, timeout and mid-packet reset.
module tb_phased_array_driver;
    localparam int NX  = 8;
    localparam int NY  = 8;
    localparam int PER = 1024;
    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [63:0] wav_out;
    logic [2:0]  win_x;
    logic [2:0]  win_y;
    logic        pkt_ok;
    logic        pkt_err;
    logic [7:0]  err_cnt;

    phased_array_driver #(.NX(NX), .NY(NY), .WIN(4), .PHASE_W(10), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wav_out(wav_out), .win_x(win_x), .win_y(win_y),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        logic       expOk, expErr;
        int         expG, expWx, expWy, expCh9, expCh10;
    } vec_t;

    vec_t tbl[20];
    int   k = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   errPulses = 0;
    int   okPulses = 0;
    int   bothHigh = 0;
    int   errExp = 0;
    int   curG = 0, curWx = 2, curWy = 2, curCh9 = 0, curCh10 = 0;

    // Edges since reset release; the counter value seen by the output register is k-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    always @(negedge clk) begin
        if (pkt_err) errPulses++;
        if (pkt_ok) okPulses++;
        if (pkt_ok && pkt_err) bothHigh++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    function automatic logic [63:0] expWave(input int kk);
        logic [63:0] r;
        r = '0;
        for (int ch = 0; ch < 64; ch++) begin
            int x, y, c, ph;
            x = ch % NX;
            y = ch / NX;
            c = (ch == 9) ? curCh9 : (ch == 10) ? curCh10 : 0;
            ph = (kk - 1 + curG + c) % PER;
            r[ch] = (x >= curWx) && (x <= curWx + 3) && (y >= curWy) && (y <= curWy + 3) && (ph < 512);
        end
        return r;
    endfunction

    function automatic int expErrCnt();
`ifdef PHASED_ARRAY_ERR_CNT_EN
        return (errExp > 255) ? 255 : errExp;
`else
        return 0;
`endif
    endfunction

    task automatic waitPhase(input int target);
        int n;
        n = 0;
        while ((k % PER) != target && n < 2100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2100) checkOutput("waitPhase_timeout", 64'(n), 64'(0));
    endtask

    task automatic checkWindowPeriod(input string tag);
        waitPhase(5);
        checkOutput({tag, "_wav5"}, wav_out, expWave(k));
        checkOutput({tag, "_win_x"}, 64'(win_x), 64'(curWx));
        checkOutput({tag, "_win_y"}, 64'(win_y), 64'(curWy));
        waitPhase(300);
        checkOutput({tag, "_wav300"}, wav_out, expWave(k));
        waitPhase(700);
        checkOutput({tag, "_wav700"}, wav_out, expWave(k));
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b0, b1, b2, b3, output logic okSeen, output logic errSeen);
        sendByte(b0);
        sendByte(b1);
        sendByte(b2);
        sendByte(b3);
        okSeen  = pkt_ok;
        errSeen = pkt_err;
    endtask

    initial begin
        logic ok, er;
        int   n, e0, o0;

        tbl[0]  = '{8'hFF, 8'h44, 8'h40, 8'h3C, 1'b1, 1'b0,  256, 3, 2,   0,   0};
        tbl[1]  = '{8'hFF, 8'h44, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 4, 2,   0,   0};
        tbl[2]  = '{8'hFF, 8'h44, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 4, 2,   0,   0};
        tbl[3]  = '{8'hFF, 8'h41, 8'h00, 8'h3B, 1'b0, 1'b1,    0, 4, 2,   0,   0};
        tbl[4]  = '{8'hFF, 8'h5A, 8'h00, 8'h3C, 1'b0, 1'b1,    0, 4, 2,   0,   0};
        tbl[5]  = '{8'hFF, 8'h57, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 4, 1,   0,   0};
        tbl[6]  = '{8'hFF, 8'h57, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 4, 0,   0,   0};
        tbl[7]  = '{8'hFF, 8'h57, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 4, 0,   0,   0};
        tbl[8]  = '{8'hFF, 8'h53, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 4, 1,   0,   0};
        tbl[9]  = '{8'hFF, 8'h41, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 3, 1,   0,   0};
        tbl[10] = '{8'hFF, 8'h41, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 2, 1,   0,   0};
        tbl[11] = '{8'hFF, 8'h41, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 1, 1,   0,   0};
        tbl[12] = '{8'hFF, 8'h49, 8'h09, 8'h3C, 1'b1, 1'b0,    0, 1, 1,   0,   0};
        tbl[13] = '{8'hFF, 8'h56, 8'h80, 8'h3C, 1'b1, 1'b0,    0, 1, 1, 512,   0};
        tbl[14] = '{8'hFF, 8'h49, 8'h40, 8'h3C, 1'b0, 1'b1,    0, 1, 1, 512,   0};
        tbl[15] = '{8'hFF, 8'h56, 8'h40, 8'h3C, 1'b1, 1'b0,    0, 1, 1, 512, 256};
        tbl[16] = '{8'hFF, 8'h50, 8'hFF, 8'h3C, 1'b1, 1'b0, 1020, 1, 1, 512, 256};
        tbl[17] = '{8'hFF, 8'h50, 8'h20, 8'h3C, 1'b1, 1'b0,  128, 1, 1, 512, 256};
        tbl[18] = '{8'hFF, 8'h41, 8'h08, 8'h3C, 1'b1, 1'b0,   32, 0, 1, 512, 256};
        tbl[19] = '{8'hFF, 8'h41, 8'h00, 8'h3C, 1'b1, 1'b0,    0, 0, 1, 512, 256};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_wav", wav_out, 64'h0);
        checkOutput("rst_win_x", 64'(win_x), 64'd2);
        checkOutput("rst_win_y", 64'(win_y), 64'd2);
        checkOutput("rst_ok_err", {62'b0, pkt_ok, pkt_err}, 64'h0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'h0);
        rst_n = 1'b1;

        checkWindowPeriod("idle");

        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, ok, er);
            checkOutput($sformatf("row%0d_pkt", i), {62'b0, ok, er}, {62'b0, tbl[i].expOk, tbl[i].expErr});
            if (tbl[i].expErr) errExp++;
            curG = tbl[i].expG;
            curWx = tbl[i].expWx;
            curWy = tbl[i].expWy;
            curCh9 = tbl[i].expCh9;
            curCh10 = tbl[i].expCh10;
            waitPhase(512);
            checkWindowPeriod($sformatf("row%0d", i));
        end
        checkOutput("err_cnt_table", 64'(err_cnt), 64'(expErrCnt()));

        // Two packets in one period: old value holds until the wrap, then the later one wins
        waitPhase(100);
        applyStimulus(8'hFF, 8'h50, 8'h10, 8'h3C, ok, er);
        waitPhase(300);
        checkOutput("lvw_before_wrap", wav_out, expWave(k));
        applyStimulus(8'hFF, 8'h50, 8'h30, 8'h3C, ok, er);
        checkOutput("lvw_pkt", {62'b0, ok, er}, 64'd2);
        curG = 192;
        waitPhase(512);
        checkWindowPeriod("lvw");

        // Inter-byte timeout
        sendByte(8'hFF);
        sendByte(8'h44);
        n = 0;
        while (!pkt_err && n < TMO + 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 64'(n), 64'(TMO));
        errExp++;
        applyStimulus(8'hFF, 8'h57, 8'h00, 8'h3C, ok, er);
        checkOutput("after_timeout_pkt", {62'b0, ok, er}, 64'd2);
        curG = 0;
        curWy = 0;
        waitPhase(512);
        checkWindowPeriod("after_timeout");
        checkOutput("err_cnt_timeout", 64'(err_cnt), 64'(expErrCnt()));

        // Reset while the parser sits in ARG
        e0 = errPulses;
        sendByte(8'hFF);
        sendByte(8'h44);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_wav", wav_out, 64'h0);
        checkOutput("midrst_win", {58'b0, win_x, win_y}, {58'b0, 3'd2, 3'd2});
        checkOutput("midrst_err_cnt", 64'(err_cnt), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        curG = 0; curWx = 2; curWy = 2; curCh9 = 0; curCh10 = 0;
        errExp = 0;
        o0 = okPulses;
        sendByte(8'h12);
        sendByte(8'h3C);
        sendByte(8'h44);
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_err", 64'(errPulses - e0), 64'h0);
        checkOutput("idle_junk_no_ok", 64'(okPulses - o0), 64'h0);
        applyStimulus(8'hFF, 8'h44, 8'h00, 8'h3C, ok, er);
        checkOutput("midrst_next_pkt", {62'b0, ok, er}, 64'd2);
        curWx = 3;
        waitPhase(512);
        checkWindowPeriod("midrst");
        checkOutput("ok_err_exclusive", 64'(bothHigh), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
